mant_op_scheduler: RTL and testbench

- Sequencer and arbiter that shares one mantissa multiply/divide datapath between two requesters (e.g. two FP lanes).
- Accepts one operation at a time through a valid/ready handshake, arbitrating round-robin.
- Holds the operands stable on the datapath for a programmable number of cycles, treating the datapath as a multi-cycle combinational path.
- Captures the selected result and returns it with the requester ID through a valid/ready response port.

---
 rtl/mant_op_scheduler.sv | 131 +++++++++++++
 tb/tb_mant_op_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mant_op_scheduler.sv
// Round-robin sequencer sharing one multi-cycle mantissa multiply/divide datapath between two requesters.
// Optional MANT_SCHED_ZERO_BYPASS_EN: trivially-zero ops skip the datapath and return 0 directly.
module mant_op_scheduler #(
    parameter int MUL_LAT = 1,
    parameter int DIV_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_op,
    input  logic [23:0] req0_a,
    input  logic [23:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_op,
    input  logic [23:0] req1_a,
    input  logic [23:0] req1_b,
    output logic [23:0] mu_a,
    output logic [23:0] mu_b,
    input  logic [47:0] mu_product,
    input  logic [26:0] mu_quotient,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic        rsp_op,
    output logic [47:0] rsp_data,
    output logic        busy
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_grant_q, last_grant_d;
    logic [23:0]      a_q, a_d, b_q, b_d;
    logic             op_q, op_d, id_q, id_d;
    logic [47:0]      data_q, data_d;

    logic             gnt_id, accept, bypass, sel_op;
    logic [23:0]      sel_a, sel_b;

    // Arbitration: a lone requester wins; on contention the one not granted last wins.
    always_comb begin
        if (req0_valid && req1_valid) gnt_id = ~last_grant_q;
        else                          gnt_id = req1_valid;
        accept = (state_q == IDLE) && (req0_valid || req1_valid);
        sel_op = gnt_id ? req1_op : req0_op;
        sel_a  = gnt_id ? req1_a  : req0_a;
        sel_b  = gnt_id ? req1_b  : req0_b;
`ifdef MANT_SCHED_ZERO_BYPASS_EN
        bypass = sel_op ? (sel_a == '0 && sel_b != '0) : (sel_a == '0 || sel_b == '0);
`else
        bypass = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = bypass ? RESP : EXEC;
            EXEC:    if (cnt_q == '0) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand registers only change on a real datapath issue so the shared unit sees no toggling.
    always_comb begin
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        id_d         = id_q;
        data_d       = data_q;
        if (accept) begin
            last_grant_d = gnt_id;
            id_d         = gnt_id;
            op_d         = sel_op;
            cnt_d        = sel_op ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
            if (bypass) begin
                data_d = '0;
            end else begin
                a_d = sel_a;
                b_d = sel_b;
            end
        end else if (state_q == EXEC) begin
            if (cnt_q == '0) data_d = op_q ? {21'b0, mu_quotient} : mu_product;
            else             cnt_d  = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= 1'b0;
            id_q         <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            id_q         <= id_d;
            data_q       <= data_d;
        end
    end

    always_comb begin
        req0_ready = (state_q == IDLE) && req0_valid && !gnt_id;
        req1_ready = (state_q == IDLE) && req1_valid && gnt_id;
        rsp_valid  = (state_q == RESP);
        busy       = (state_q != IDLE);
    end

    assign mu_a     = a_q;
    assign mu_b     = b_q;
    assign rsp_id   = id_q;
    assign rsp_op   = op_q;
    assign rsp_data = data_q;

endmodule

// File: tb/tb_mant_op_scheduler.sv
// Scoreboard bench for mant_op_scheduler: random two-requester traffic against a latency/arbitration model.
module tb_mant_op_scheduler;
    localparam int MUL_LAT = 1;
    localparam int DIV_LAT = 4;

    logic        clk = 0, rst_n = 0;
    logic        req0_valid = 0, req0_op = 0, req1_valid = 0, req1_op = 0;
    logic [23:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic        req0_ready, req1_ready;
    logic [23:0] mu_a, mu_b;
    logic [47:0] mu_product;
    logic [26:0] mu_quotient;
    logic        rsp_valid, rsp_ready = 0, rsp_id, rsp_op, busy;
    logic [47:0] rsp_data;

    int total = 0, bad = 0;
    int rr_mode = 0;
    int cyc = 0;

    mant_op_scheduler #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .mu_a(mu_a), .mu_b(mu_b), .mu_product(mu_product), .mu_quotient(mu_quotient),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_op(rsp_op),
        .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [26:0] quot(input logic [23:0] a, input logic [23:0] b);
        logic [49:0] n;
        n = {a, 26'd0};
        if (b == 0) return '1;
        return 27'(n / 50'(b));
    endfunction

    // Datapath model: outputs are garbage until the operands have been stable for the op latency.
    int hc = 0;
    logic [23:0] pa = 0, pb = 0;
    always @(negedge clk) begin
        if (mu_a != pa || mu_b != pb) hc = 0;
        else if (hc < 1000) hc = hc + 1;
        pa = mu_a;
        pb = mu_b;
    end
    assign mu_product  = (hc >= MUL_LAT - 1) ? 48'(mu_a) * 48'(mu_b) : 48'hDEADBEEF0BAD;
    assign mu_quotient = (hc >= DIV_LAT - 1) ? quot(mu_a, mu_b) : 27'h5A5A5A5;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    initial forever begin
        @(posedge clk); #1;
        case (rr_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = ($urandom_range(0, 2) != 0);
            default: rsp_ready = 1'b0;
        endcase
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        logic        id;
        logic        op;
        logic [47:0] data;
        int          acc_cyc;
        int          lat;
        bit          seen;
    } exp_t;
    exp_t sb[$];

    logic        lg_m = 1'b1;
    logic [23:0] cur_a = 0, cur_b = 0;
    bit          hold_p = 0;
    logic        p_id, p_op;
    logic [47:0] p_data;

    always @(negedge clk) begin
        exp_t e;
        logic w, op;
        logic [23:0] a, b;
        bit byp;
        if (!rst_n) begin
            sb.delete();
            lg_m = 1'b1;
            hold_p = 0;
            cur_a = 0;
            cur_b = 0;
        end else begin
            if (hold_p)
                chk("rsp_hold", {rsp_valid, rsp_id, rsp_op, rsp_data}, {1'b1, p_id, p_op, p_data});
            if (busy) begin
                chk("ready_busy", {req1_ready, req0_ready}, 2'b00);
                if (!rsp_valid) chk("mu_stable", {mu_a, mu_b}, {cur_a, cur_b});
            end else if (req0_valid || req1_valid) begin
                w = (req0_valid && req1_valid) ? ~lg_m : req1_valid;
                chk("grant", {req1_ready, req0_ready}, w ? 2'b10 : 2'b01);
                lg_m = w;
                op = w ? req1_op : req0_op;
                a  = w ? req1_a : req0_a;
                b  = w ? req1_b : req0_b;
`ifdef MANT_SCHED_ZERO_BYPASS_EN
                byp = op ? (a == 0 && b != 0) : (a == 0 || b == 0);
`else
                byp = 0;
`endif
                e.id = w;
                e.op = op;
                e.data = op ? {21'b0, quot(a, b)} : 48'(a) * 48'(b);
                e.acc_cyc = cyc;
                e.lat = byp ? 1 : ((op ? DIV_LAT : MUL_LAT) + 1);
                e.seen = 0;
                if (byp) e.data = '0;
                else begin cur_a = a; cur_b = b; end
                sb.push_back(e);
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 1'b0);
                end else begin
                    if (!sb[0].seen) begin
                        chk("latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat));
                        sb[0].seen = 1;
                    end
                    if (rsp_ready) begin
                        e = sb.pop_front();
                        chk("rsp_id", rsp_id, e.id);
                        chk("rsp_op", rsp_op, e.op);
                        chk("rsp_data", rsp_data, e.data);
                    end
                end
            end
            hold_p = rsp_valid && !rsp_ready;
            p_id = rsp_id;
            p_op = rsp_op;
            p_data = rsp_data;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit id, input bit op, input logic [23:0] a, input logic [23:0] b);
        int n = 0;
        if (id) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
        do begin
            @(negedge clk);
            n++;
        end while (!(id ? req1_ready : req0_ready) && n < 300);
        if (n >= 300) timeout(id ? "req1_accept" : "req0_accept");
        @(posedge clk); #1;
        if (id) req1_valid = 0; else req0_valid = 0;
    endtask

    function automatic logic [23:0] pick();
        case ($urandom_range(0, 7))
            0:       return 24'h0;
            1:       return 24'hFFFFFF;
            2, 3:    return 24'($urandom());
            default: return {1'b1, 23'($urandom())};
        endcase
    endfunction

    task automatic rand_stream(input bit id, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            drive(id, 1'($urandom_range(0, 1)), pick(), pick());
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || sb.size() != 0 || req0_valid || req1_valid) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) timeout("drain");
    endtask

    initial begin
        int n;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {rsp_valid, busy, rsp_id, rsp_op, req0_ready, req1_ready}, 6'b0);
        chk("rst_mu", {mu_a, mu_b}, 48'h0);
        chk("rst_data", rsp_data, 48'h0);
        rst_n = 1;

        // contention right after reset: req0 mul then req1 div
        fork
            drive(0, 0, 24'h800000, 24'h800000);
            drive(1, 1, 24'hC00000, 24'h800000);
        join
        wait_idle();
        fork
            drive(0, 0, 24'h800001, 24'h7FFFFF);
            drive(1, 0, 24'hABCDEF, 24'h800000);
        join
        wait_idle();

        // zero operands
        drive(0, 0, 24'h0, 24'hFFFFFF);
        wait_idle();
        drive(1, 1, 24'h0, 24'h900000);
        wait_idle();
        drive(1, 1, 24'h900000, 24'h0);
        wait_idle();

        // back-pressure: response held 5 cycles while req0 waits
        rr_mode = 2;
        @(posedge clk); #1;
        drive(1, 0, 24'h123456, 24'h654321);
        fork drive(0, 1, 24'h800000, 24'hC00000); join_none
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) timeout("bp_rsp_valid");
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("bp_ready", {req1_ready, req0_ready}, 2'b00);
            chk("bp_busy", busy, 1'b1);
        end
        rr_mode = 0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_busy", busy, 1'b0);
        chk("bp_idle_ready", req0_ready, 1'b1);
        wait fork;
        wait_idle();

        // random traffic with random back-pressure
        rr_mode = 1;
        fork
            rand_stream(0, 40);
            rand_stream(1, 40);
        join
        rr_mode = 0;
        wait_idle();

        // reset during the 2nd EXEC cycle of a divide
        drive(0, 1, 24'hC00000, 24'h800000);
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("arst_outputs", {rsp_valid, busy, rsp_id, rsp_op, req0_ready, req1_ready}, 6'b0);
        chk("arst_mu", {mu_a, mu_b}, 48'h0);
        chk("arst_data", rsp_data, 48'h0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("arst_no_rsp", {rsp_valid, busy}, 2'b00);
        end
        @(posedge clk); #1;
        fork
            drive(0, 0, 24'hFFFFFF, 24'hFFFFFF);
            drive(1, 0, 24'h800000, 24'hA00000);
        join_none
        @(negedge clk);
        chk("arst_grant", {req1_ready, req0_ready}, 2'b01);
        wait fork;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
